// File: rtl/mux_vector_sequencer.sv
// Hardware stimulus/capture sequencer for a 4-input mux block.
// Sweeps every input code, holds each one for DWELL cycles, and records F into a truth table.
module mux_vector_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    hold,
  input  logic                    f_in,
  output logic [WIDTH-1:0]        x_out,
  output logic                    busy,
  output logic                    done,
  output logic [(2**WIDTH)-1:0]   truth
);

  localparam int unsigned DEPTH = 2**WIDTH;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [WIDTH-1:0] X_LAST   = WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DEPTH-1:0]   truth_q, truth_d;

  // State and datapath registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      truth_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      truth_q <= truth_d;
    end
  end

  // Next-state and next-output logic; done/busy are computed one cycle ahead so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    truth_d = truth_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        x_d    = '0;
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          busy_d  = 1'b1;
          truth_d = '0;
        end
      end

      S_DRIVE: begin
        if (!hold) begin
          if (cnt_q == CNT_LAST) begin
            // End of dwell: capture F for the current code, then advance or finish.
            truth_d[x_q] = f_in;
            cnt_d        = '0;
            if (x_q == X_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              x_d     = '0;
            end else begin
              x_d = x_q + WIDTH'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        x_d     = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        x_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign x_out = x_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign truth = truth_q;

endmodule

// File: doc/mux_vector_sequencer.md
Name: mux_vector_sequencer

Overview:
- Self-checking stimulus/capture stage wrapped around the 4-input mux function block (inputs A..D, output F).
- Steps an exhaustive input vector through all 2^WIDTH codes and holds each one for DWELL cycles.
- Samples the mux output F at the end of each dwell and assembles the truth table into a register.
- Replaces hand-written delay-list stimulus with a start/done-controlled hardware sequencer usable in sim and on board.

Parameters:
- WIDTH, 4, width of driven input vector; sequence length is 2^WIDTH.
- DWELL, 10, clock cycles each vector is held (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new sweep; sampled only in IDLE.
- hold  in  1  freezes dwell counter and vector while high (DRIVE only).
- f_in  in  1  mux output F being characterised.
- x_out  out  WIDTH  vector driven to mux inputs (MSB..LSB = D..A ordering fixed by integrator).
- busy  out  1  high while sweep in progress.
- done  out  1  single-cycle pulse after final sample.
- truth  out  2^WIDTH  captured truth table; bit i = f_in sampled while x_out==i.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x_out=0, dwell counter=0, busy=0, done=0, truth=0. Takes effect immediately, including mid-sweep; sweep is abandoned, no done pulse.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at edge e0 -> DRIVE, x_out=0, cnt=0, busy=1, truth cleared to 0.
  - start=0 -> stay; truth retains last result.
- DRIVE:
  - hold=1: cnt and x_out frozen, no sample taken.
  - hold=0 and cnt<DWELL-1: cnt increments.
  - hold=0 and cnt==DWELL-1: truth[x_out] <= f_in on that edge and cnt <= 0.
    - If x_out==2^WIDTH-1 -> DONE.
    - Else x_out increments by 1 (no wrap inside sweep).
- DONE (exactly one cycle): done=1, busy=0, x_out=0; next edge -> IDLE, done=0.
- Timing with hold never asserted:
  - Vector k is driven during cycles e0+k*DWELL .. e0+(k+1)*DWELL-1.
  - Vector k is sampled at edge e0+(k+1)*DWELL.
  - done is high during cycle e0+2^WIDTH*DWELL.
- Each hold-high cycle in DRIVE extends the total by one cycle.
- DWELL=1: every DRIVE cycle samples and advances.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- hold outside DRIVE: ignored.
- truth bits not yet sampled in the current sweep read 0.
- f_in is treated as synchronous to clk; no synchroniser inside.
- cnt width is 8 bits; cnt never exceeds DWELL-1.

Test Plan:
- Reset then start pulse; bench model f_in = x_out[3]^x_out[0] -> x_out walks 0..15, 10 cycles each; done pulses during cycle e0+160; truth=16'h55AA; busy low.
- f_in tied 1, DWELL=1 -> done during cycle e0+16, truth=16'hFFFF; second start clears truth to 0 in the cycle after e0, then refills to 16'hFFFF.
- hold asserted 5 cycles while x_out==3 -> x_out stays 3 for 15 cycles; done delayed to e0+165; truth unchanged versus the no-hold run.
- start re-pulsed at x_out==7 mid-sweep -> ignored; sweep completes normally; only one done pulse.
- rst_n dropped at x_out==9 -> x_out, busy, truth go 0 immediately with no clock; no done pulse; a fresh start afterwards yields a full correct table.
- start held high constantly -> back-to-back sweeps with one DONE cycle plus one IDLE cycle between them; done pulses every 162 cycles.
